// File: rtl/iambic_keyer_if.sv
// Host command bus for the keyer: 6-bit address, 32-bit data, one-cycle request strobe.
// Latency: none; this is a plain wire bundle.
// Backpressure: none; the slave accepts every strobe.
interface iambic_keyer_if;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_rqst;

  modport master (output cmd_addr, cmd_data, cmd_rqst);
  modport slave  (input  cmd_addr, cmd_data, cmd_rqst);
endinterface

// File: rtl/iambic_keyer.sv
// Iambic Morse keyer: straight, iambic-A and iambic-B paddle keying with wpm-derived unit timing.
// Latency: key_out changes on the msec_pulse edge that sees the paddle change; config lands next clk edge.
// Backpressure: none; commands are taken every cycle, all keying activity advances only on msec_pulse.
module iambic_keyer (
  input  logic          clk,
  input  logic          rst_n,
  iambic_keyer_if.slave cmd,
  input  logic          msec_pulse,
  input  logic          dot_key_debounced,
  input  logic          dash_key_debounced,
  output logic          key_out,
  output logic          keyer_busy
);

  typedef enum logic [1:0] {S_IDLE, S_DOT, S_DASH, S_GAP} state_t;

  localparam logic        LAST_DOT  = 1'b0;
  localparam logic        LAST_DASH = 1'b1;
  localparam logic [5:0]  CFG_ADDR  = 6'h0F;
  localparam logic [11:0] UNIT_DIV  = 12'd1200;

  state_t      state_q, state_d;
  logic [5:0]  wpm_q, wpm_d;
  logic [1:0]  mode_q, mode_d;
  logic [10:0] acc_q, acc_d;
  logic [1:0]  units_q, units_d;
  logic        key_q, key_d;
  logic        dot_mem_q, dot_mem_d;
  logic        dash_mem_q, dash_mem_d;
  logic        last_q, last_d;
  // Mode-B flag captured when leaving IDLE so a mode write never alters an element in flight.
  logic        run_b_q, run_b_d;

  logic [5:0]  wpm_eff;
  logic [11:0] acc_sum;
  logic [11:0] acc_wrap;
  logic        unit_tick;
  logic        dot;
  logic        dash;
  logic        unused_cmd_bits;

  assign dot  = dot_key_debounced;
  assign dash = dash_key_debounced;
  assign unused_cmd_bits = ^{cmd.cmd_data[31:30], cmd.cmd_data[23:18], cmd.cmd_data[15:0]};

  // Host config register writes, independent of msec_pulse.
  always_comb begin
    wpm_d  = wpm_q;
    mode_d = mode_q;
    if (cmd.cmd_rqst && (cmd.cmd_addr == CFG_ADDR)) begin
      wpm_d  = cmd.cmd_data[29:24];
      mode_d = cmd.cmd_data[17:16];
    end
  end

  // Clamp wpm to 1..60 and form the fractional-unit accumulator step (uses the currently stored wpm).
  always_comb begin
    if (wpm_q == 6'd0)       wpm_eff = 6'd1;
    else if (wpm_q > 6'd60)  wpm_eff = 6'd60;
    else                     wpm_eff = wpm_q;
    acc_sum   = {1'b0, acc_q} + {6'd0, wpm_eff};
    acc_wrap  = acc_sum - UNIT_DIV;
    unit_tick = (acc_sum >= UNIT_DIV);
  end

  // Keyer next-state: element sequencing, paddle memories and key output, all gated by msec_pulse.
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    units_d    = units_q;
    acc_d      = acc_q;
    dot_mem_d  = dot_mem_q;
    dash_mem_d = dash_mem_q;
    last_d     = last_q;
    run_b_d    = run_b_q;

    if (msec_pulse) begin
      acc_d = unit_tick ? acc_wrap[10:0] : acc_sum[10:0];
      case (state_q)
        S_IDLE: begin
          run_b_d = mode_q[1];
          if (mode_q == 2'b00) begin
            key_d = dot;
          end else if (dot) begin
            state_d    = S_DOT;
            key_d      = 1'b1;
            units_d    = 2'd1;
            acc_d      = '0;
            dash_mem_d = dash;
          end else if (dash) begin
            state_d = S_DASH;
            key_d   = 1'b1;
            units_d = 2'd3;
            acc_d   = '0;
          end else begin
            key_d = 1'b0;
          end
        end

        S_DOT, S_DASH: begin
          if (run_b_q) begin
            if ((state_q == S_DOT) && dash) dash_mem_d = 1'b1;
            if ((state_q == S_DASH) && dot) dot_mem_d  = 1'b1;
          end
          if (unit_tick) begin
            if (units_q <= 2'd1) begin
              state_d = S_GAP;
              units_d = 2'd1;
              key_d   = 1'b0;
              last_d  = (state_q == S_DASH) ? LAST_DASH : LAST_DOT;
            end else begin
              units_d = units_q - 2'd1;
            end
          end
        end

        S_GAP: begin
          if (run_b_q) begin
            if ((last_q == LAST_DOT) && dash) dash_mem_d = 1'b1;
            if ((last_q == LAST_DASH) && dot) dot_mem_d  = 1'b1;
          end
          if (unit_tick) begin
            if (units_q <= 2'd1) begin
              // Alternate first, then repeat the held paddle, otherwise go idle.
              if ((last_q == LAST_DOT) && (dash || dash_mem_q)) begin
                state_d    = S_DASH;
                key_d      = 1'b1;
                units_d    = 2'd3;
                dash_mem_d = 1'b0;
              end else if ((last_q == LAST_DASH) && (dot || dot_mem_q)) begin
                state_d   = S_DOT;
                key_d     = 1'b1;
                units_d   = 2'd1;
                dot_mem_d = 1'b0;
              end else if ((last_q == LAST_DOT) && dot) begin
                state_d = S_DOT;
                key_d   = 1'b1;
                units_d = 2'd1;
              end else if ((last_q == LAST_DASH) && dash) begin
                state_d = S_DASH;
                key_d   = 1'b1;
                units_d = 2'd3;
              end else begin
                state_d    = S_IDLE;
                key_d      = 1'b0;
                dot_mem_d  = 1'b0;
                dash_mem_d = 1'b0;
              end
            end else begin
              units_d = units_q - 2'd1;
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and config registers; reset drops key_out immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      key_q      <= 1'b0;
      acc_q      <= '0;
      units_q    <= '0;
      dot_mem_q  <= 1'b0;
      dash_mem_q <= 1'b0;
      last_q     <= LAST_DOT;
      run_b_q    <= 1'b0;
      wpm_q      <= 6'd20;
      mode_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      acc_q      <= acc_d;
      units_q    <= units_d;
      dot_mem_q  <= dot_mem_d;
      dash_mem_q <= dash_mem_d;
      last_q     <= last_d;
      run_b_q    <= run_b_d;
      wpm_q      <= wpm_d;
      mode_q     <= mode_d;
    end
  end

  assign key_out    = key_q;
  assign keyer_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_iambic_keyer.sv
// Bench for iambic_keyer: element-level behavioural model compared every cycle, plus literal timing pins.
// Latency: model updates on the same clk edge as the DUT, outputs compared on the falling edge.
// Backpressure: not applicable; stimulus drives msec_pulse, paddles and config writes freely.
module tb_iambic_keyer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic msec_pulse = 1'b0;
  logic dot = 1'b0;
  logic dash = 1'b0;
  logic key_out;
  logic keyer_busy;

  iambic_keyer_if cmd_if();

  always #5 clk = ~clk;

  iambic_keyer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cmd                (cmd_if),
    .msec_pulse         (msec_pulse),
    .dot_key_debounced  (dot),
    .dash_key_debounced (dash),
    .key_out            (key_out),
    .keyer_busy         (keyer_busy)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // ---------------- behavioural model ----------------
  // An element is a symbol (dot = 1 unit, dash = 3 units) followed by a 1-unit space;
  // m_key tells whether we are in the keyed part or the trailing space of m_cur.
  localparam int NONE = 0;
  localparam int SYM_DOT = 1;
  localparam int SYM_DASH = 2;

  int       m_wpm, m_acc, m_cur, m_left;
  bit [1:0] m_mode;
  bit       m_b, m_key, m_busy, m_mdot, m_mdash;

  function automatic int eff_wpm(input int w);
    return (w == 0) ? 1 : ((w > 60) ? 60 : w);
  endfunction

  task automatic m_reset();
    m_wpm = 20; m_mode = 2'b00; m_acc = 0; m_cur = NONE; m_left = 0;
    m_b = 1'b0; m_key = 1'b0; m_busy = 1'b0; m_mdot = 1'b0; m_mdash = 1'b0;
  endtask

  task automatic m_start(input int s);
    m_cur = s; m_key = 1'b1; m_busy = 1'b1;
    m_left = (s == SYM_DOT) ? 1 : 3;
  endtask

  task automatic m_next(input bit d, input bit h);
    bit other_pad, same_pad, other_mem;
    other_pad = (m_cur == SYM_DOT) ? h : d;
    same_pad  = (m_cur == SYM_DOT) ? d : h;
    other_mem = (m_cur == SYM_DOT) ? m_mdash : m_mdot;
    if (other_pad || other_mem) begin
      if (m_cur == SYM_DOT) begin m_mdash = 1'b0; m_start(SYM_DASH); end
      else begin m_mdot = 1'b0; m_start(SYM_DOT); end
    end else if (same_pad) begin
      m_start(m_cur);
    end else begin
      m_busy = 1'b0; m_cur = NONE; m_key = 1'b0; m_mdot = 1'b0; m_mdash = 1'b0;
    end
  endtask

  task automatic m_ms(input bit d, input bit h);
    int e;
    bit tick;
    e = eff_wpm(m_wpm);
    tick = (m_acc + e >= 1200);
    m_acc = tick ? (m_acc + e - 1200) : (m_acc + e);
    if (!m_busy) begin
      if (m_mode == 2'b00) m_key = d;
      else begin
        m_b = m_mode[1];
        if (d) begin m_start(SYM_DOT); m_acc = 0; m_mdash = h; end
        else if (h) begin m_start(SYM_DASH); m_acc = 0; end
        else m_key = 1'b0;
      end
    end else begin
      if (m_b && (m_cur == SYM_DOT) && h) m_mdash = 1'b1;
      if (m_b && (m_cur == SYM_DASH) && d) m_mdot = 1'b1;
      if (tick) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_key) begin m_key = 1'b0; m_left = 1; end
          else m_next(d, h);
        end
      end
    end
  endtask

  // Model advances on the same edge the DUT samples; timing step sees the old wpm.
  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else begin
        if (msec_pulse) m_ms(dot, dash);
        if (cmd_if.cmd_rqst && (cmd_if.cmd_addr == 6'h0F)) begin
          m_wpm  = int'(cmd_if.cmd_data[29:24]);
          m_mode = cmd_if.cmd_data[17:16];
        end
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        vectors++;
        if (key_out !== m_key) begin
          miscompares++;
          $display("FAIL key_out @%0t: dut=%b model=%b", $time, key_out, m_key);
        end
        vectors++;
        if (keyer_busy !== m_busy) begin
          miscompares++;
          $display("FAIL keyer_busy @%0t: dut=%b model=%b", $time, keyer_busy, m_busy);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse();
    @(negedge clk) msec_pulse = 1'b1;
    @(negedge clk) msec_pulse = 1'b0;
  endtask

  task automatic cfg(input int w, input bit [1:0] m);
    logic [31:0] d;
    @(negedge clk);
    d = $urandom;
    d[29:24] = 6'(w);
    d[17:16] = m;
    cmd_if.cmd_addr = 6'h0F;
    cmd_if.cmd_data = d;
    cmd_if.cmd_rqst = 1'b1;
    @(negedge clk) cmd_if.cmd_rqst = 1'b0;
  endtask

  // Apply pulses until key_out (or keyer_busy) equals val; n counts pulses, capped at limit.
  task automatic pulses_until(input bit use_busy, input bit val, input int limit, output int n);
    n = 0;
    do begin
      pulse();
      n++;
    end while ((((use_busy ? keyer_busy : key_out)) !== val) && (n < limit));
  endtask

  int n;

  initial begin
    cmd_if.cmd_addr = '0;
    cmd_if.cmd_data = '0;
    cmd_if.cmd_rqst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_key_out", int'(key_out), 0);
    check("reset_busy", int'(keyer_busy), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Mode A single dot at 20 wpm.
    cfg(20, 2'b01);
    dot = 1'b1; pulse(); dot = 1'b0;
    pulses_until(1'b0, 1'b0, 100, n); check("dot20_high", n, 60);
    pulses_until(1'b1, 1'b0, 100, n); check("dot20_gap", n, 60);

    // Mode A dash held: 180 on, 60 off, repeating.
    dash = 1'b1; pulse();
    pulses_until(1'b0, 1'b0, 300, n); check("dash_hold_on1", n, 180);
    pulses_until(1'b0, 1'b1, 300, n); check("dash_hold_off1", n, 60);
    pulses_until(1'b0, 1'b0, 300, n); check("dash_hold_on2", n, 180);
    pulses_until(1'b0, 1'b1, 300, n); check("dash_hold_off2", n, 60);
    dash = 1'b0;
    pulses_until(1'b1, 1'b0, 400, n); check("dash_drain", n, 240);

    // Mode B at 30 wpm: dash tapped during a held dot gives dot then dash.
    cfg(30, 2'b10);
    dot = 1'b1; pulse();
    repeat (3) pulse();
    dash = 1'b1; pulse(); dash = 1'b0; dot = 1'b0;
    pulses_until(1'b0, 1'b0, 200, n); check("modeB_dot_rest", n, 36);
    pulses_until(1'b0, 1'b1, 200, n); check("modeB_gap1", n, 40);
    pulses_until(1'b0, 1'b0, 400, n); check("modeB_dash", n, 120);
    pulses_until(1'b1, 1'b0, 200, n); check("modeB_gap2", n, 40);

    // Same stimulus in mode A: the dash tap is forgotten.
    cfg(30, 2'b01);
    dot = 1'b1; pulse();
    repeat (3) pulse();
    dash = 1'b1; pulse(); dash = 1'b0; dot = 1'b0;
    pulses_until(1'b0, 1'b0, 200, n); check("modeA_dot_rest", n, 36);
    pulses_until(1'b1, 1'b0, 200, n); check("modeA_gap", n, 40);
    check("modeA_no_dash", int'(key_out), 0);

    // Straight key: follows dot with one-pulse latency, never busy, dash ignored.
    cfg(20, 2'b00);
    for (int i = 0; i < 4; i++) begin
      dot = (i % 2 == 0);
      dash = 1'($urandom);
      pulse();
      check("straight_key", int'(key_out), int'(dot));
      check("straight_busy", int'(keyer_busy), 0);
    end
    dot = 1'b0; dash = 1'b0; pulse();

    // Clamped wpm extremes.
    cfg(0, 2'b01);
    dot = 1'b1; pulse(); dot = 1'b0;
    pulses_until(1'b0, 1'b0, 1300, n); check("wpm0_dot", n, 1200);
    pulses_until(1'b1, 1'b0, 1300, n); check("wpm0_gap", n, 1200);
    cfg(63, 2'b01);
    dot = 1'b1; pulse(); dot = 1'b0;
    pulses_until(1'b0, 1'b0, 100, n); check("wpm63_dot", n, 20);
    pulses_until(1'b1, 1'b0, 100, n); check("wpm63_gap", n, 20);

    // wpm raised mid-dash: acc and remaining units carry over.
    cfg(20, 2'b01);
    dash = 1'b1; pulse(); dash = 1'b0;
    repeat (30) pulse();
    cfg(60, 2'b01);
    pulses_until(1'b0, 1'b0, 300, n); check("middash_rest", n, 50);
    pulses_until(1'b1, 1'b0, 100, n); check("middash_gap", n, 20);

    // Asynchronous reset in the middle of a dash.
    cfg(20, 2'b10);
    dash = 1'b1; pulse();
    repeat (50) pulse();
    check("pre_reset_key", int'(key_out), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_key", int'(key_out), 0);
    check("async_reset_busy", int'(keyer_busy), 0);
    dash = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    check("reset_wpm", int'(dut.wpm_q), 20);
    check("reset_mode", int'(dut.mode_q), 0);
    dot = 1'b1; pulse();
    check("post_reset_straight", int'(key_out), 1);
    check("post_reset_busy", int'(keyer_busy), 0);
    dot = 1'b0; pulse();

    // Random traffic: paddles, pulses, config writes (some coincident with pulses, some to other addresses).
    cfg(40, 2'b10);
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      msec_pulse = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) dot = ~dot;
      if ($urandom_range(0, 31) == 0) dash = ~dash;
      cmd_if.cmd_rqst = 1'b0;
      if ($urandom_range(0, 299) == 0) begin
        logic [31:0] d;
        d = $urandom;
        d[29:24] = 6'($urandom_range(20, 63));
        cmd_if.cmd_addr = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0F;
        cmd_if.cmd_data = d;
        cmd_if.cmd_rqst = 1'b1;
      end
    end
    @(negedge clk);
    msec_pulse = 1'b0; dot = 1'b0; dash = 1'b0; cmd_if.cmd_rqst = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iambic_keyer.md
IAMBIC_KEYER -- requirements
Module: iambic_keyer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all other ports SHALL be synchronous to clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 cmd_addr  input  6  host command address.
REQ-005 cmd_data  input  32  host command data.
REQ-006 cmd_rqst  input  1  one-cycle strobe qualifying cmd_addr/cmd_data.
REQ-007 msec_pulse  input  1  one-cycle strobe every 1 ms; clock enable for all timing.
REQ-008 dot_key_debounced  input  1  debounced dot paddle, or straight key in mode 00.
REQ-009 dash_key_debounced  input  1  debounced dash paddle.
REQ-010 key_out  output  1  keyed signal, fed to the downstream CW T/R sequencer's key input.
REQ-011 keyer_busy  output  1  high whenever state is not IDLE.

Function
REQ-012 Config write: cmd_rqst with cmd_addr==6'h0F SHALL load wpm<=cmd_data[29:24] and mode<=cmd_data[17:16] in the same clk edge.
REQ-013 Effective wpm SHALL be 1 when the stored value is 0 and 60 when it exceeds 60; otherwise the stored value.
REQ-014 Mode: 00 straight, 01 iambic A, 10 iambic B; 11 SHALL behave as 10.
REQ-015 Unit timing: 11-bit accumulator acc; on each msec_pulse, if acc+wpm>=1200 then acc<=acc+wpm-1200 and unit_tick asserts for that pulse, else acc<=acc+wpm.
REQ-016 Unit length SHALL therefore average 1200/wpm ms exactly, e.g. 60 ms at 20 wpm, 20 ms at 60 wpm.
REQ-017 acc SHALL be cleared on every transition out of IDLE, so the first element has full length.
REQ-018 States: IDLE, DOT, DASH, GAP; every state, counter, memory and key_out update SHALL occur only on clk edges where msec_pulse=1.
REQ-019 IDLE, mode 00: key_out<=dot_key_debounced; dash_key_debounced ignored; the state SHALL remain IDLE.
REQ-020 IDLE, mode 01/10: dot asserted goes to DOT; else dash asserted goes to DASH; if both are asserted, DOT wins and dash_mem is set.
REQ-021 DOT: key_out=1, units<=1 on entry; DASH: key_out=1, units<=3 on entry.
REQ-022 In DOT and DASH, each unit_tick SHALL decrement units; at 0 the state goes to GAP with units<=1, key_out=0, last<=element.
REQ-023 Mode B memory: while in DOT, or in GAP after DOT, dash asserted sets dash_mem; while in DASH, or in GAP after DASH, dot asserted sets dot_mem.
REQ-024 In mode A, memories SHALL stay 0 except as set by REQ-020.
REQ-025 End of GAP, at the unit_tick reaching 0: if last=DOT and (dash or dash_mem), go to DASH; else if last=DASH and (dot or dot_mem), go to DOT; else if the paddle of last is asserted, repeat last; else IDLE.
REQ-026 The memory consumed by a transition SHALL be cleared; both memories SHALL be cleared on entry to IDLE.
REQ-027 A wpm write mid-element SHALL take effect at the next msec_pulse without resetting acc or units.
REQ-028 A mode write SHALL be sampled only in IDLE; an element in progress completes under the old mode.
REQ-029 cmd_rqst and msec_pulse in the same cycle: the config write and the timing step SHALL both occur, the step using the old wpm.
REQ-030 key_out SHALL be registered and glitch-free; keyer_busy=0 exactly when state=IDLE.

Reset
REQ-031 On rst_n=0 the block SHALL asynchronously force: state=IDLE, key_out=0, keyer_busy=0, acc=0, units=0, dot_mem=dash_mem=0, last=DOT, wpm=20, mode=00.
REQ-032 Deassertion of rst_n SHALL take effect at the first clk edge after release; a reset mid-element SHALL drop key_out immediately.

Verification
REQ-033 Mode 01, wpm 20, dot held for 1 ms then released -> key_out high for exactly 60 msec_pulses, then low; return to IDLE after 60 more.
REQ-034 Mode 01, wpm 20, dash held continuously -> key_out repeats 180 pulses high, 60 pulses low.
REQ-035 Mode 10, wpm 30: dot held; dash tapped for 1 ms during the dot; both released -> dot 40, gap 40, dash 120, gap 40, then IDLE. The same stimulus in mode 01 -> dot only.
REQ-036 Mode 00: dot toggled 1/0/1 on successive pulses -> key_out follows with one-pulse latency; keyer_busy stays 0; dash has no effect.
REQ-037 Wpm config 0 -> 1200-pulse dot; wpm config 63 -> 20-pulse dot. A wpm write mid-dash changes the remaining unit rate only.
REQ-038 rst_n pulsed low mid-dash -> key_out=0 asynchronously; after release, wpm=20, mode=00, state IDLE.
